// File: rtl/simul_axi_pkg.sv
// rtl/simul_axi_pkg.sv - shared AXI field widths, burst codes and arbiter state encoding
package simul_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/simul_rr_arbiter.sv
// rtl/simul_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module simul_rr_arbiter
  import simul_axi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_eligible
);

  int idx;

  // Walk from the farthest candidate to the nearest so the nearest eligible index wins
  always_comb begin
    grant        = '0;
    any_eligible = 1'b0;
    idx          = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (eligible[idx]) begin
        grant        = IDX_W'(idx);
        any_eligible = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simul_axi_rdaddr_arbiter.sv
// rtl/simul_axi_rdaddr_arbiter.sv - round-robin read-address arbiter with outstanding limit (optional trace: SIMUL_AXI_RDARB_LOG_EN)
module simul_axi_rdaddr_arbiter
  import simul_axi_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int IDX_W           = 2,
  parameter int ID_WIDTH        = 12,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ack,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  req_arid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*LEN_W-1:0]     req_arlen,
  input  logic [NUM_REQ*SIZE_W-1:0]    req_arsize,
  input  logic [NUM_REQ*BURST_W-1:0]   req_arburst,
  input  logic [NUM_REQ*CACHE_W-1:0]   req_arcache,
  input  logic [NUM_REQ*PROT_W-1:0]    req_arprot,
  input  logic [NUM_REQ-1:0]           rdone,
  output logic [ID_WIDTH-1:0]          arid_in,
  output logic [ADDRESS_WIDTH-1:0]     araddr_in,
  output logic [LEN_W-1:0]             arlen_in,
  output logic [SIZE_W-1:0]            arsize_in,
  output logic [BURST_W-1:0]           arburst_in,
  output logic [CACHE_W-1:0]           arcache_in,
  output logic [PROT_W-1:0]            arprot_in,
  output logic                         set_cmd,
  input  logic                         ready,
  output logic                         outstanding_err
);

  localparam int         LOW_W   = ID_WIDTH - IDX_W;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  arb_state_t           state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant;
  logic                 any_eligible;
  logic                 grant_fire;
  logic [3:0]           cnt [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   take;
  logic [NUM_REQ-1:0]   cnt_zero;
  logic                 err_event;

  logic [LOW_W-1:0]         sel_arid_low;
  logic [ADDRESS_WIDTH-1:0] sel_araddr;
  logic [LEN_W-1:0]         sel_arlen;
  logic [SIZE_W-1:0]        sel_arsize;
  logic [BURST_W-1:0]       sel_arburst;
  logic [CACHE_W-1:0]       sel_arcache;
  logic [PROT_W-1:0]        sel_arprot;

  assign sel_arid_low = req_arid[int'(grant)*ID_WIDTH +: LOW_W];
  assign sel_araddr   = req_araddr[int'(grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign sel_arlen    = req_arlen[int'(grant)*LEN_W +: LEN_W];
  assign sel_arsize   = req_arsize[int'(grant)*SIZE_W +: SIZE_W];
  assign sel_arburst  = req_arburst[int'(grant)*BURST_W +: BURST_W];
  assign sel_arcache  = req_arcache[int'(grant)*CACHE_W +: CACHE_W];
  assign sel_arprot   = req_arprot[int'(grant)*PROT_W +: PROT_W];

  // A grant is only decided in IDLE, so back-to-back commands are always a cycle apart
  assign grant_fire = (state == ST_IDLE) && ready && any_eligible;
  assign err_event  = |(rdone & ~take & cnt_zero);

  // Per-requester eligibility, one-hot grant and empty-counter flags
  always_comb begin
    eligible = '0;
    take     = '0;
    cnt_zero = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt[i] < MAX_CNT);
      take[i]     = grant_fire && (grant == IDX_W'(i));
      cnt_zero[i] = (cnt[i] == 4'd0);
    end
  end

  simul_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .eligible     (eligible),
    .last_grant   (last_grant),
    .grant        (grant),
    .any_eligible (any_eligible)
  );

  // Decision/issue FSM: latch the winner's command and pulse set_cmd and req_ack for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      set_cmd    <= 1'b0;
      req_ack    <= '0;
      arid_in    <= '0;
      araddr_in  <= '0;
      arlen_in   <= '0;
      arsize_in  <= '0;
      arburst_in <= '0;
      arcache_in <= '0;
      arprot_in  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            arid_in    <= {grant, sel_arid_low};
            araddr_in  <= sel_araddr;
            arlen_in   <= sel_arlen;
            arsize_in  <= sel_arsize;
            arburst_in <= sel_arburst;
            arcache_in <= sel_arcache;
            arprot_in  <= sel_arprot;
            set_cmd    <= 1'b1;
            req_ack    <= take;
            last_grant <= grant;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          set_cmd <= 1'b0;
          req_ack <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-burst counters; a completion with nothing outstanding raises the sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= 4'd0;
      outstanding_err <= 1'b0;
    end else begin
      if (err_event) outstanding_err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rdone[i] && !take[i]) begin
          if (!cnt_zero[i]) cnt[i] <= cnt[i] - 4'd1;
        end else if (take[i] && !rdone[i]) begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

`ifdef SIMUL_AXI_RDARB_LOG_EN
  // Trace each grant and each outstanding-count underflow
  always_ff @(posedge clk) begin
    if (!reset && grant_fire)
      $display("%0t rdarb grant req=%0d arid=%h araddr=%h beats=%0d", $time, grant,
               {grant, sel_arid_low}, sel_araddr, {1'b0, sel_arlen} + 5'd1);
    if (!reset && err_event)
      $display("%0t rdarb warning: rdone with no outstanding burst (rdone=%b)", $time, rdone);
  end
`else
  // Default build carries no trace output
`endif

endmodule
